// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin front end that time-shares one sequential
// shift-and-add multiplier core among R requesters. Each accepted operand
// pair is launched on the core, the product (or a watchdog abort) is held
// for the issuing requester until it takes it, then arbitration resumes.
module mul_arbiter #(
    parameter int N       = 8,
    parameter int R       = 4,
    parameter int TIMEOUT = 32
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic [R-1:0]     i_req_valid,
    output logic [R-1:0]     o_req_ready,
    input  logic [R*N-1:0]   i_req_multiplicand,
    input  logic [R*N-1:0]   i_req_multiplier,
    output logic [R-1:0]     o_resp_valid,
    input  logic [R-1:0]     i_resp_ready,
    output logic [2*N-1:0]   o_resp_product,
    output logic             o_resp_error,
    output logic             o_busy,
    output logic             o_core_reset,
    output logic             o_core_start,
    output logic [N-1:0]     o_core_multiplicand,
    output logic [N-1:0]     o_core_multiplier,
    input  logic             i_core_finished,
    input  logic [2*N-1:0]   i_core_product
);

    localparam int GW = (R > 1) ? $clog2(R) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    state_t        state;
    logic [GW-1:0] ptr;
    logic [GW-1:0] grant;
    logic [GW-1:0] winner;
    logic [CW-1:0] wdog;
    logic          any_req;
    logic [N-1:0]  win_mcand;
    logic [N-1:0]  win_mplier;

    // First valid requester after the last-served one, wrapping around.
    // Scanning from the far end lets the closest match overwrite the others.
    function automatic logic [GW-1:0] pick(input logic [R-1:0] valid,
                                           input logic [GW-1:0] last);
        logic [GW-1:0] win;
        int            cand;
        win = last;
        for (int i = R; i >= 1; i--) begin
            cand = (int'(last) + i) % R;
            if (valid[cand[GW-1:0]]) begin
                win = GW'(cand);
            end
        end
        return win;
    endfunction

    assign any_req      = |i_req_valid;
    assign winner       = pick(i_req_valid, ptr);
    assign o_req_ready  = (state == ST_IDLE && any_req) ? (R'(1) << winner) : '0;
    assign o_resp_valid = (state == ST_RESPOND) ? (R'(1) << grant) : '0;
    assign o_busy       = (state != ST_IDLE);

    // Route the winning requester's operand pair to the latch inputs.
    always_comb begin
        win_mcand  = '0;
        win_mplier = '0;
        for (int k = 0; k < R; k++) begin
            if (winner == GW'(k)) begin
                win_mcand  = i_req_multiplicand[k*N +: N];
                win_mplier = i_req_multiplier[k*N +: N];
            end
        end
    end

    // Sequencer: grant, launch the core, wait with watchdog, hold the response.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state               <= ST_IDLE;
            ptr                 <= GW'(R - 1);
            grant               <= '0;
            wdog                <= '0;
            o_core_start        <= 1'b0;
            o_core_reset        <= 1'b1;
            o_core_multiplicand <= '0;
            o_core_multiplier   <= '0;
            o_resp_product      <= '0;
            o_resp_error        <= 1'b0;
        end else begin
            o_core_start <= 1'b0;
            o_core_reset <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant               <= winner;
                        o_core_multiplicand <= win_mcand;
                        o_core_multiplier   <= win_mplier;
                        o_core_start        <= 1'b1;
                        state               <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    wdog  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_core_finished) begin
                        o_resp_product <= i_core_product;
                        o_resp_error   <= 1'b0;
                        state          <= ST_RESPOND;
                    end else if (wdog == CW'(TIMEOUT - 1)) begin
                        // Core never answered: kick it and report an error.
                        o_core_reset   <= 1'b1;
                        o_resp_product <= '0;
                        o_resp_error   <= 1'b1;
                        state          <= ST_RESPOND;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_RESPOND: begin
                    if (i_resp_ready[grant]) begin
                        ptr          <= grant;
                        o_resp_error <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed sequence with random operands around mul_arbiter,
// using a behavioural multiplier core stub and a round-robin reference model.
module tb_mul_arbiter;

    localparam int N       = 8;
    localparam int R       = 4;
    localparam int TIMEOUT = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [R-1:0]     req_valid;
    logic [R-1:0]     req_ready;
    logic [R*N-1:0]   req_mcand;
    logic [R*N-1:0]   req_mplier;
    logic [R-1:0]     resp_valid;
    logic [R-1:0]     resp_ready;
    logic [2*N-1:0]   resp_product;
    logic             resp_error;
    logic             busy;
    logic             core_reset;
    logic             core_start;
    logic [N-1:0]     core_mcand;
    logic [N-1:0]     core_mplier;
    logic             core_finished = 1'b0;
    logic [2*N-1:0]   core_product  = '0;

    int checks   = 0;
    int failures = 0;
    int ptr_m;
    int cr_count;
    bit suppress = 1'b0;

    mul_arbiter #(.N(N), .R(R), .TIMEOUT(TIMEOUT)) dut (
        .i_clock            (clk),
        .i_reset_n          (rst_n),
        .i_req_valid        (req_valid),
        .o_req_ready        (req_ready),
        .i_req_multiplicand (req_mcand),
        .i_req_multiplier   (req_mplier),
        .o_resp_valid       (resp_valid),
        .i_resp_ready       (resp_ready),
        .o_resp_product     (resp_product),
        .o_resp_error       (resp_error),
        .o_busy             (busy),
        .o_core_reset       (core_reset),
        .o_core_start       (core_start),
        .o_core_multiplicand(core_mcand),
        .o_core_multiplier  (core_mplier),
        .i_core_finished    (core_finished),
        .i_core_product     (core_product)
    );

    always #5 clk = ~clk;

    // Core stub: finished pulses N cycles after the start cycle.
    int   rem    = 0;
    logic active = 1'b0;
    always @(posedge clk) begin
        core_finished <= 1'b0;
        if (core_reset) begin
            active <= 1'b0;
        end else if (core_start) begin
            active       <= 1'b1;
            rem          <= N - 1;
            core_product <= (2*N)'(core_mcand) * (2*N)'(core_mplier);
        end else if (active) begin
            if (rem == 1) begin
                active <= 1'b0;
                if (!suppress) core_finished <= 1'b1;
            end else begin
                rem <= rem - 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "simulation time limit");
    end

    function automatic logic [2*N-1:0] mul(input logic [N-1:0] a, input logic [N-1:0] b);
        return (2*N)'(a) * (2*N)'(b);
    endfunction

    function automatic int model_winner(input logic [R-1:0] v, input int last);
        for (int i = 1; i <= R; i++) begin
            if (v[(last + i) % R]) return (last + i) % R;
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at negedge+1 in IDLE with requests already driven.
    task automatic accept(input int w);
        check("req_ready_grant", 64'(req_ready), 64'(R'(1) << w));
        cr_count = 0;
        @(negedge clk); #1;
        check("core_start", 64'(core_start), 64'd1);
        check("busy_launch", 64'(busy), 64'd1);
        check("core_mcand", 64'(core_mcand), 64'(req_mcand[w*N +: N]));
        check("core_mplier", 64'(core_mplier), 64'(req_mplier[w*N +: N]));
    endtask

    task automatic wait_resp(input int w, input logic [2*N-1:0] exp_p, input bit exp_err);
        int lat;
        bit seen;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < TIMEOUT + 10) begin
            @(negedge clk); #1;
            lat++;
            if (core_reset) cr_count++;
            if (resp_valid != '0) seen = 1'b1;
        end
        check("resp_seen", 64'(seen), 64'd1);
        check("resp_latency", 64'(lat), exp_err ? 64'(TIMEOUT + 2) : 64'(N + 2));
        check("resp_valid", 64'(resp_valid), 64'(R'(1) << w));
        check("resp_product", 64'(resp_product), 64'(exp_p));
        check("resp_error", 64'(resp_error), 64'(exp_err));
    endtask

    task automatic respond(input int w, input int hold, input logic [2*N-1:0] exp_p, input bit exp_err);
        for (int i = 0; i < hold; i++) begin
            resp_ready = ~(R'(1) << w);
            @(negedge clk); #1;
            if (core_reset) cr_count++;
            check("hold_product", 64'(resp_product), 64'(exp_p));
            check("hold_valid", 64'(resp_valid), 64'(R'(1) << w));
            check("hold_no_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = R'(1) << w;
        @(negedge clk); #1;
        resp_ready = '0;
        if (core_reset) cr_count++;
        check("busy_after_resp", 64'(busy), 64'd0);
        check("resp_valid_clear", 64'(resp_valid), 64'd0);
        check("core_reset_pulses", 64'(cr_count), 64'(exp_err));
        ptr_m = w;
    endtask

    task automatic run_op(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                          input int hold, input bit err);
        logic [2*N-1:0] p;
        int w;
        p = err ? '0 : mul(a, b);
        @(negedge clk); #1;
        req_valid = R'(1) << k;
        req_mcand[k*N +: N]  = a;
        req_mplier[k*N +: N] = b;
        #1;
        w = model_winner(req_valid, ptr_m);
        accept(w);
        req_valid = '0;
        wait_resp(w, p, err);
        respond(w, hold, p, err);
    endtask

    initial begin
        logic [N-1:0] a1, b1, a2, b2;
        int w;
        int stray;

        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        req_mcand  = '0;
        req_mplier = '0;
        ptr_m      = R - 1;

        // Reset state
        @(negedge clk); #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_core_start", 64'(core_start), 64'd0);
        check("rst_resp_error", 64'(resp_error), 64'd0);
        check("rst_resp_product", 64'(resp_product), 64'd0);
        check("rst_core_reset", 64'(core_reset), 64'd1);
        check("rst_core_mcand", 64'(core_mcand), 64'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("core_reset_release", 64'(core_reset), 64'd0);

        // Fairness: all requesters valid, five grants
        for (int k = 0; k < R; k++) begin
            req_mcand[k*N +: N]  = N'(k + 1);
            req_mplier[k*N +: N] = N'(k + 2);
        end
        req_valid = '1;
        #1;
        for (int i = 0; i < 5; i++) begin
            w = model_winner(req_valid, ptr_m);
            accept(w);
            wait_resp(w, mul(N'(w + 1), N'(w + 2)), 1'b0);
            respond(w, 0, mul(N'(w + 1), N'(w + 2)), 1'b0);
        end
        req_valid = '0;

        // Single request and corner operands
        run_op(0, 8'd3, 8'd5, 0, 1'b0);
        run_op(1, 8'd255, 8'd255, 0, 1'b0);
        run_op(2, 8'd0, 8'd200, 1, 1'b0);
        run_op(3, 8'd1, 8'd255, 2, 1'b0);

        // Random requesters and operands
        for (int i = 0; i < 6; i++) begin
            run_op(int'($urandom_range(R - 1, 0)), N'($urandom), N'($urandom),
                   int'($urandom_range(3, 0)), 1'b0);
        end

        // Response backpressure with a competing request
        a1 = N'($urandom); b1 = N'($urandom);
        a2 = N'($urandom); b2 = N'($urandom);
        @(negedge clk); #1;
        req_valid = 4'b0010;
        req_mcand[1*N +: N]  = a1;
        req_mplier[1*N +: N] = b1;
        #1;
        accept(model_winner(req_valid, ptr_m));
        req_valid = 4'b0100;
        req_mcand[2*N +: N]  = a2;
        req_mplier[2*N +: N] = b2;
        wait_resp(1, mul(a1, b1), 1'b0);
        respond(1, 10, mul(a1, b1), 1'b0);
        accept(model_winner(req_valid, ptr_m));
        req_valid = '0;
        wait_resp(2, mul(a2, b2), 1'b0);
        respond(2, 0, mul(a2, b2), 1'b0);

        // Watchdog abort then normal recovery
        suppress = 1'b1;
        run_op(3, N'($urandom), N'($urandom), 1, 1'b1);
        suppress = 1'b0;
        run_op(0, N'($urandom), N'($urandom), 0, 1'b0);

        // Mid-operation reset
        @(negedge clk); #1;
        req_valid = 4'b0100;
        req_mcand[2*N +: N]  = 8'd9;
        req_mplier[2*N +: N] = 8'd7;
        #1;
        accept(model_winner(req_valid, ptr_m));
        req_valid = '0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_core_start", 64'(core_start), 64'd0);
        check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("mid_rst_core_reset", 64'(core_reset), 64'd1);
        check("mid_rst_product", 64'(resp_product), 64'd0);
        check("mid_rst_core_mcand", 64'(core_mcand), 64'd0);
        ptr_m = R - 1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_core_reset_held", 64'(core_reset), 64'd1);
        @(negedge clk); #1;
        check("mid_rst_core_reset_clear", 64'(core_reset), 64'd0);
        stray = 0;
        repeat (N + 4) begin
            @(negedge clk); #1;
            if (resp_valid != '0 || busy) stray++;
        end
        check("mid_rst_no_response", 64'(stray), 64'd0);
        req_valid = 4'b0011;
        req_mcand[0 +: N]    = 8'd12;
        req_mplier[0 +: N]   = 8'd11;
        req_mcand[N +: N]    = 8'd4;
        req_mplier[N +: N]   = 8'd4;
        #1;
        w = model_winner(req_valid, ptr_m);
        accept(w);
        req_valid = '0;
        wait_resp(w, mul(req_mcand[w*N +: N], req_mplier[w*N +: N]), 1'b0);
        respond(w, 0, mul(req_mcand[w*N +: N], req_mplier[w*N +: N]), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
